// File: rtl/reset_sequencer.sv
// Staged reset generator: synchronises reset requests, stretches them, then runs the
// memory initializer before releasing downstream stages in order. Optional init watchdog: RSTSEQ_TIMEOUT_EN.
module reset_sequencer #(
  parameter int N_SRC        = 2,
  parameter int HOLD_CYCLES  = 16,
  parameter int N_STAGES     = 3,
  parameter int STAGE_GAP    = 4,
  parameter int INIT_TIMEOUT = 8192
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N_SRC-1:0]    rst_req,
  input  logic                init_done,
  output logic                init_start,
  output logic                init_rst,
  output logic [N_STAGES-1:0] stage_rst,
  output logic                busy,
  output logic [N_SRC-1:0]    cause,
  output logic                timeout_err
);

  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_INIT    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
  localparam logic [1:0] ST_RUN     = 2'd3;

  localparam int HOLD_W   = $clog2(HOLD_CYCLES) + 1;
  localparam int LAST_GAP = (N_STAGES - 1) * STAGE_GAP;
  localparam int GAP_W    = $clog2(LAST_GAP) + 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(LAST_GAP);

  logic [N_SRC-1:0]    req_meta_p0;
  logic [N_SRC-1:0]    req_s;
  logic                req_any;

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [HOLD_W-1:0]   hold_nxt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [GAP_W-1:0]    gap_nxt;
  logic [N_STAGES-1:0] stage_nxt;
  logic                timeout_hit;

  // Stage k is released once the gap counter has covered k gaps.
  function automatic logic [N_STAGES-1:0] release_mask(input logic [GAP_W-1:0] gap);
    logic [N_STAGES-1:0] m;
    m = '0;
    for (int k = 0; k < N_STAGES; k++) begin
      m[k] = (int'(gap) >= k * STAGE_GAP);
    end
    return m;
  endfunction

  // Request synchroniser, stage 0 (metastability) and stage 1 (req_s)
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      req_meta_p0 <= '0;
      req_s       <= '0;
    end else begin
      req_meta_p0 <= rst_req;
      req_s       <= req_meta_p0;
    end
  end

  assign req_any = |req_s;

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    gap_nxt   = gap_cnt;
    case (state)
      ST_HOLD: begin
        if (req_any) begin
          hold_nxt = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt = ST_INIT;
          hold_nxt  = '0;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      ST_INIT: begin
        if (req_any) begin
          state_nxt = ST_HOLD;
        end else if (init_done || timeout_hit) begin
          state_nxt = (LAST_GAP == 0) ? ST_RUN : ST_RELEASE;
          gap_nxt   = '0;
        end
      end
      ST_RELEASE: begin
        if (req_any) begin
          state_nxt = ST_HOLD;
        end else begin
          if (gap_cnt != GAP_LAST) gap_nxt = gap_cnt + 1'b1;
          if (gap_nxt == GAP_LAST) state_nxt = ST_RUN;
        end
      end
      default: begin
        if (req_any) state_nxt = ST_HOLD;
      end
    endcase
    if (state_nxt != ST_HOLD) hold_nxt = '0;
    if (state_nxt != ST_RELEASE) gap_nxt = '0;
  end

  always_comb begin
    case (state_nxt)
      ST_RELEASE: stage_nxt = ~release_mask(gap_nxt);
      ST_RUN:     stage_nxt = '0;
      default:    stage_nxt = '1;
    endcase
  end

  // Registered FSM state, counters and outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_HOLD;
      hold_cnt   <= '0;
      gap_cnt    <= '0;
      init_rst   <= 1'b1;
      stage_rst  <= '1;
      init_start <= 1'b0;
      busy       <= 1'b1;
      cause      <= '0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_nxt;
      gap_cnt    <= gap_nxt;
      init_rst   <= (state_nxt == ST_HOLD);
      stage_rst  <= stage_nxt;
      init_start <= (state == ST_HOLD) && (state_nxt == ST_INIT);
      busy       <= (state_nxt != ST_RUN);
      if (state_nxt == ST_HOLD) begin
        cause <= (state == ST_HOLD) ? (cause | req_s) : req_s;
      end
    end
  end

`ifdef RSTSEQ_TIMEOUT_EN
  localparam int INIT_W = $clog2(INIT_TIMEOUT) + 1;
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_TIMEOUT - 1);

  logic [INIT_W-1:0] init_cnt;

  assign timeout_hit = (state == ST_INIT) && !init_done && (init_cnt == INIT_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      init_cnt <= '0;
    end else if ((state == ST_INIT) && (state_nxt == ST_INIT)) begin
      if (init_cnt != INIT_LAST) init_cnt <= init_cnt + 1'b1;
    end else begin
      init_cnt <= '0;
    end
  end

  // Only a forced release counts as a timeout; a competing request wins the cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      timeout_err <= 1'b0;
    end else if (timeout_hit && !req_any) begin
      timeout_err <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  // INIT_TIMEOUT only matters when the watchdog is built.
  assign unused_timeout_cfg = ^INIT_TIMEOUT;
  assign timeout_hit        = 1'b0;
  assign timeout_err        = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: a table of timed vectors through a scoreboard
// queue, then hand-written multi-cycle sequences (stretch, abort, simultaneous, timeout).
module tb_reset_sequencer;

  localparam int HOLD = 16;
  localparam int GAP  = 4;
  localparam int TMO  = 32;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] rst_req = 2'b00;
  logic       init_done = 1'b0;
  logic       init_start;
  logic       init_rst;
  logic [2:0] stage_rst;
  logic       busy;
  logic [1:0] cause;
  logic       timeout_err;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    string      name;
    logic       rn;
    logic [1:0] req;
    logic       done;
    int         cyc;
    logic [8:0] exp;
  } vec_t;

  vec_t       tbl[$];
  logic [8:0] sb[$];

  reset_sequencer #(
    .N_SRC(2), .HOLD_CYCLES(HOLD), .N_STAGES(3), .STAGE_GAP(GAP), .INIT_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rst_req(rst_req), .init_done(init_done),
    .init_start(init_start), .init_rst(init_rst), .stage_rst(stage_rst),
    .busy(busy), .cause(cause), .timeout_err(timeout_err)
  );

  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] snap();
    return {stage_rst, busy, init_rst, init_start, cause, timeout_err};
  endfunction

  function automatic logic [8:0] ex(input logic [2:0] st, input logic b, input logic ir,
                                    input logic is, input logic [1:0] c);
    return {st, b, ir, is, c, 1'b0};
  endfunction

  task automatic add(input string name, input logic rn, input logic [1:0] req,
                     input logic done, input int cyc, input logic [8:0] exp);
    vec_t v;
    v.name = name; v.rn = rn; v.req = req; v.done = done; v.cyc = cyc; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic wait_start(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      n++;
      if (init_start === 1'b1) break;
    end
  endtask

  initial begin
    int n, t1, t2, tb, bad, saw_start;
    logic [8:0] got, exp;

    add("t_reset",       1'b0, 2'b00, 1'b0, 2,  ex(3'b111, 1, 1, 0, 2'b00));
    add("t_hold15",      1'b1, 2'b00, 1'b0, 15, ex(3'b111, 1, 1, 0, 2'b00));
    add("t_init_entry",  1'b1, 2'b00, 1'b0, 1,  ex(3'b111, 1, 0, 1, 2'b00));
    add("t_init_wait",   1'b1, 2'b00, 1'b0, 1,  ex(3'b111, 1, 0, 0, 2'b00));
    add("t_rel0",        1'b1, 2'b00, 1'b1, 1,  ex(3'b110, 1, 0, 0, 2'b00));
    add("t_rel1",        1'b1, 2'b00, 1'b1, 4,  ex(3'b100, 1, 0, 0, 2'b00));
    add("t_run",         1'b1, 2'b00, 1'b1, 4,  ex(3'b000, 0, 0, 0, 2'b00));
    add("t_req_e0",      1'b1, 2'b01, 1'b1, 1,  ex(3'b000, 0, 0, 0, 2'b00));
    add("t_req_e1",      1'b1, 2'b00, 1'b1, 1,  ex(3'b000, 0, 0, 0, 2'b00));
    add("t_req_e2",      1'b1, 2'b00, 1'b1, 1,  ex(3'b111, 1, 1, 0, 2'b01));
    add("t_cause_or",    1'b1, 2'b10, 1'b0, 3,  ex(3'b111, 1, 1, 0, 2'b11));
    add("t_rehold",      1'b1, 2'b00, 1'b0, 18, ex(3'b111, 1, 0, 1, 2'b11));
    add("t_rel0_again",  1'b1, 2'b00, 1'b1, 1,  ex(3'b110, 1, 0, 0, 2'b11));
    add("t_midseq_rstn", 1'b0, 2'b00, 1'b1, 1,  ex(3'b111, 1, 1, 0, 2'b00));
    add("t_after_rstn",  1'b1, 2'b00, 1'b0, 16, ex(3'b111, 1, 0, 1, 2'b00));

    for (int i = 0; i < tbl.size(); i++) begin
      reset_n   = tbl[i].rn;
      rst_req   = tbl[i].req;
      init_done = tbl[i].done;
      sb.push_back(tbl[i].exp);
      repeat (tbl[i].cyc) tick();
      got = snap();
      if (sb.size() == 0) begin
        chk({tbl[i].name, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
        exp = sb.pop_front();
        chk(tbl[i].name, got, exp);
      end
    end

    // Power-up with measured timing
    reset_n = 1'b0; rst_req = 2'b00; init_done = 1'b0;
    repeat (3) tick();
    chk("pu_reset_state", snap(), ex(3'b111, 1, 1, 0, 2'b00));
    reset_n = 1'b1;
    wait_start(n);
    chk("pu_hold_to_init", n, HOLD);
    chk("pu_init_rst_low", init_rst, 1'b0);
    tick();
    chk("pu_init_start_1cyc", init_start, 1'b0);
    repeat (8) tick();
    init_done = 1'b1;
    tick();
    chk("pu_stage0_on_done", stage_rst, 3'b110);
    t1 = -1; t2 = -1; tb = -1; bad = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (t1 < 0 && stage_rst[1] == 1'b0) t1 = i;
      if (t2 < 0 && stage_rst[2] == 1'b0) t2 = i;
      if (tb < 0 && busy == 1'b0) tb = i;
      if ((stage_rst[2] == 1'b0 && stage_rst[1] == 1'b1) || stage_rst[0] == 1'b1) bad++;
    end
    chk("pu_stage1_offset", t1, GAP);
    chk("pu_stage2_offset", t2, 2 * GAP);
    chk("pu_busy_offset", tb, 2 * GAP);
    chk("pu_monotonic", bad, 0);
    chk("pu_run_state", snap(), ex(3'b000, 0, 0, 0, 2'b00));

    // Single-cycle request while running
    rst_req = 2'b10;
    tick();
    rst_req = 2'b00; init_done = 1'b0;
    chk("run_req_e0", stage_rst, 3'b000);
    tick();
    chk("run_req_e1", stage_rst, 3'b000);
    tick();
    chk("run_req_e2", snap(), ex(3'b111, 1, 1, 0, 2'b10));
    wait_start(n);
    chk("run_req_rehold", n, HOLD);
    init_done = 1'b1;
    tick();
    chk("run_req_rel0", stage_rst, 3'b110);
    repeat (2 * GAP) tick();
    chk("run_req_rerun", snap(), ex(3'b000, 0, 0, 0, 2'b10));

    // Glitchy request must keep the block in HOLD
    init_done = 1'b0; saw_start = 0; bad = 0;
    for (int i = 0; i < 40; i++) begin
      rst_req = (((i / 5) % 2) == 0) ? 2'b01 : 2'b00;
      tick();
      if (init_start) saw_start++;
      if (i >= 2 && (stage_rst != 3'b111 || busy != 1'b1)) bad++;
    end
    chk("glitch_no_init", saw_start, 0);
    chk("glitch_held", bad, 0);
    wait_start(n);
    chk("glitch_stretch_len", 5 + n, HOLD + 2);
    chk("glitch_cause", cause, 2'b01);

    // Abort partway through the staged release
    init_done = 1'b1;
    tick();
    chk("abort_rel0", stage_rst, 3'b110);
    bad = 0;
    tick();
    if (stage_rst[2:1] != 2'b11 || !busy) bad++;
    rst_req = 2'b10;
    tick();
    if (stage_rst[2:1] != 2'b11 || !busy) bad++;
    rst_req = 2'b00; init_done = 1'b0;
    tick();
    chk("abort_f3", stage_rst, 3'b110);
    tick();
    chk("abort_reassert", snap(), ex(3'b111, 1, 1, 0, 2'b10));
    for (int i = 0; i < 4; i++) begin
      tick();
      if (stage_rst != 3'b111 || !busy) bad++;
    end
    chk("abort_never_released", bad, 0);

    // init_done and a request seen on the same edge: request wins
    wait_start(n);
    chk("simul_rehold", n + 4, HOLD);
    rst_req = 2'b01;
    tick();
    rst_req = 2'b00;
    tick();
    init_done = 1'b1;
    tick();
    chk("simul_hold", snap(), ex(3'b111, 1, 1, 0, 2'b01));
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (stage_rst != 3'b111 || !busy) bad++;
    end
    chk("simul_no_release", bad, 0);

    // Initializer that never finishes
    init_done = 1'b0;
    wait_start(n);
`ifdef RSTSEQ_TIMEOUT_EN
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      n++;
      if (timeout_err) break;
    end
    chk("tmo_cycles", n, TMO);
    chk("tmo_rel0", stage_rst, 3'b110);
    repeat (2 * GAP) tick();
    chk("tmo_run", snap(), {3'b000, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1});
    rst_req = 2'b01;
    tick();
    rst_req = 2'b00;
    repeat (2) tick();
    chk("tmo_sticky", {stage_rst, timeout_err}, {3'b111, 1'b1});
    reset_n = 1'b0;
    tick();
    chk("tmo_cleared", snap(), ex(3'b111, 1, 1, 0, 2'b00));
`else
    repeat (60) tick();
    chk("no_tmo_waits", snap(), ex(3'b111, 1, 0, 0, 2'b01));
    reset_n = 1'b0;
    tick();
    chk("no_tmo_reset", snap(), ex(3'b111, 1, 1, 0, 2'b00));
`endif
    reset_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
